ysyx22041405_mem_arbiter: RTL and testbench

YSYX22041405_MEM_ARBITER -- requirements
Module: ysyx22041405_mem_arbiter

---
 rtl/ysyx22041405_mem_arbiter_pkg.sv | 32 +++
 rtl/ysyx22041405_arb2.sv | 39 +++
 rtl/ysyx22041405_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_ysyx22041405_mem_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx22041405_mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state/owner encodings, mask width
// and the fixed-priority grant helper.
package ysyx22041405_mem_arbiter_pkg;

   localparam int MASK_W = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_IF   = 2'd1;
   localparam logic [1:0] OWN_LS   = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      WAIT = ST_WAIT
   } state_t;

   typedef enum logic [1:0] {
      O_NONE = OWN_NONE,
      O_IF   = OWN_IF,
      O_LS   = OWN_LS
   } owner_t;

   // Returns {ls_grant, if_grant}; load/store always beats fetch.
   function automatic logic [1:0] fixed_grant(input logic ls_valid, input logic if_valid);
      return {ls_valid, if_valid & ~ls_valid};
   endfunction

endpackage

// File: rtl/ysyx22041405_arb2.sv
// Two-way grant logic (LS vs IF). YSYX22041405_ARB_RR_EN selects round-robin
// with a pointer register; otherwise fixed priority LS over IF, stateless.
module ysyx22041405_arb2
   import ysyx22041405_mem_arbiter_pkg::*;
(
`ifdef YSYX22041405_ARB_RR_EN
   input  logic clk,
   input  logic rst,
   input  logic advance,
`endif
   input  logic ls_valid,
   input  logic if_valid,
   output logic ls_grant,
   output logic if_grant
);

`ifdef YSYX22041405_ARB_RR_EN
   // ptr_ls=1 means LS wins a tie; it flips to the loser after every grant
   logic ptr_ls;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_ls <= 1'b1;
      end else if (advance) begin
         ptr_ls <= if_grant;
      end
   end

   always_comb begin
      ls_grant = ls_valid & (~if_valid | ptr_ls);
      if_grant = if_valid & (~ls_valid | ~ptr_ls);
   end
`else
   always_comb begin
      {ls_grant, if_grant} = fixed_grant(ls_valid, if_valid);
   end
`endif

endmodule

// File: rtl/ysyx22041405_mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory port, one transaction
// in flight. Arbitration policy set by YSYX22041405_ARB_RR_EN (see arb2).
module ysyx22041405_mem_arbiter
   import ysyx22041405_mem_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req_valid,
   input  logic [WIDTH-1:0]  if_addr,
   output logic              if_req_ready,
   output logic              if_rsp_valid,
   output logic [WIDTH-1:0]  if_rdata,
   input  logic              ls_req_valid,
   input  logic [WIDTH-1:0]  ls_addr,
   input  logic              ls_we,
   input  logic [WIDTH-1:0]  ls_wdata,
   input  logic [MASK_W-1:0] ls_wmask,
   output logic              ls_req_ready,
   output logic              ls_rsp_valid,
   output logic [WIDTH-1:0]  ls_rdata,
   output logic              mem_req_valid,
   output logic [WIDTH-1:0]  mem_addr,
   output logic              mem_we,
   output logic [WIDTH-1:0]  mem_wdata,
   output logic [MASK_W-1:0] mem_wmask,
   input  logic              mem_req_ready,
   input  logic              mem_rsp_valid,
   input  logic [WIDTH-1:0]  mem_rdata
);

   state_t            state, state_nx;
   owner_t            owner, owner_nx;
   logic [WIDTH-1:0]  addr_q, wdata_q;
   logic              we_q;
   logic [MASK_W-1:0] wmask_q;
   logic              ls_gnt, if_gnt;
   logic              take, rsp_hit;

   ysyx22041405_arb2 u_arb2 (
`ifdef YSYX22041405_ARB_RR_EN
      .clk      (clk),
      .rst      (rst),
      .advance  (take),
`endif
      .ls_valid (ls_req_valid),
      .if_valid (if_req_valid),
      .ls_grant (ls_gnt),
      .if_grant (if_gnt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         owner   <= O_NONE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else begin
         state <= state_nx;
         owner <= owner_nx;
         if (take) begin
            // fetches go out as plain reads regardless of the LS inputs
            if (ls_gnt) begin
               addr_q  <= ls_addr;
               we_q    <= ls_we;
               wdata_q <= ls_wdata;
               wmask_q <= ls_wmask;
            end else begin
               addr_q  <= if_addr;
               we_q    <= 1'b0;
               wdata_q <= '0;
               wmask_q <= '0;
            end
         end
      end
   end

   always_comb begin
      state_nx      = state;
      owner_nx      = owner;
      ls_req_ready  = 1'b0;
      if_req_ready  = 1'b0;
      take          = 1'b0;
      rsp_hit       = 1'b0;
      mem_req_valid = 1'b0;
      case (state)
         IDLE: begin
            // rst gates the readies so nothing is granted while held in reset
            ls_req_ready = ls_gnt & ~rst;
            if_req_ready = if_gnt & ~rst;
            take         = ls_req_ready | if_req_ready;
            if (take) begin
               state_nx = REQ;
               owner_nx = ls_gnt ? O_LS : O_IF;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nx = WAIT;
         end
         WAIT: begin
            rsp_hit = mem_rsp_valid;
            if (mem_rsp_valid) begin
               state_nx = IDLE;
               owner_nx = O_NONE;
            end
         end
         default: begin
            state_nx = IDLE;
            owner_nx = O_NONE;
         end
      endcase
   end

   always_comb begin
      ls_rsp_valid = rsp_hit & (owner == O_LS);
      if_rsp_valid = rsp_hit & (owner == O_IF);
      ls_rdata     = ls_rsp_valid ? mem_rdata : '0;
      if_rdata     = if_rsp_valid ? mem_rdata : '0;
      mem_addr     = addr_q;
      mem_we       = we_q;
      mem_wdata    = wdata_q;
      mem_wmask    = wmask_q;
   end

endmodule

// File: tb/tb_ysyx22041405_mem_arbiter.sv
// Scoreboard bench for ysyx22041405_mem_arbiter: directed scenarios plus random
// traffic against a behavioural requester/memory model.
module tb_ysyx22041405_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [31:0] if_addr, if_rdata;
   logic        ls_req_valid, ls_we, ls_req_ready, ls_rsp_valid;
   logic [31:0] ls_addr, ls_wdata, ls_rdata;
   logic [7:0]  ls_wmask;
   logic        mem_req_valid, mem_we, mem_req_ready, mem_rsp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_wmask;

   always #5 clk = ~clk;

   ysyx22041405_mem_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_addr(if_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
      .ls_req_valid(ls_req_valid), .ls_addr(ls_addr), .ls_we(ls_we),
      .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_req_ready(ls_req_ready),
      .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
      .mem_req_valid(mem_req_valid), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
      logic [7:0]  wmask;
   } mreq_t;

   typedef struct packed {
      logic        we;
      logic [31:0] data;
   } rsp_t;

   int checks = 0;
   int failures = 0;

   mreq_t       exp_mem[$];
   rsp_t        ls_exp[$];
   logic [31:0] if_exp[$];
   mreq_t       ls_inj[$];
   logic [31:0] if_inj[$];
   logic [31:0] hs_log[$];
   bit          gnt_log[$];

   bit          if_pend, ls_pend, busy, gnt_last, ptr_ls;
   mreq_t       ls_cur;
   logic [31:0] if_cur;
   bit          rand_en = 0, spur_en = 0;
   int          rdy_mode = 2, rsp_lat = 2;
   bit          mem_inflight = 0;
   int          mem_cnt = 0;
   logic [31:0] mem_data;
   int          ls_rsp_cnt = 0, if_rsp_cnt = 0;
   logic [31:0] last_ls_rdata, last_if_rdata;
   mreq_t       held;
   bit          hold_v;

   // memory contents: a fixed function of the address
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return a ^ 32'h5EAD_BEFF;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit tb_idle();
      return !if_pend && !ls_pend && !busy && !mem_inflight && ls_inj.size() == 0 &&
             if_inj.size() == 0 && exp_mem.size() == 0 && ls_exp.size() == 0 &&
             if_exp.size() == 0;
   endfunction

   // requester + memory model
   initial begin
      bit exp_ls;
      if_req_valid = 0; if_addr = 0; ls_req_valid = 0; ls_addr = 0; ls_we = 0;
      ls_wdata = 0; ls_wmask = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
      if_pend = 0; ls_pend = 0; busy = 0; gnt_last = 0; ptr_ls = 1;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 0; gnt_last = 0; if_pend = 0; ls_pend = 0; ptr_ls = 1;
            exp_mem.delete(); ls_exp.delete(); if_exp.delete();
         end else begin
            chk("ready_exclusive", {31'd0, ls_req_ready & if_req_ready}, 32'd0);
            if (gnt_last) chk("req_one_cycle_after_grant", {31'd0, mem_req_valid}, 32'd1);
            if (busy) begin
               chk("ready_while_busy", {30'd0, ls_req_ready, if_req_ready}, 32'd0);
            end else begin
               chk("idle_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
               if (ls_pend || if_pend) begin
`ifdef YSYX22041405_ARB_RR_EN
                  exp_ls = ls_pend && (!if_pend || ptr_ls);
`else
                  exp_ls = ls_pend;
`endif
                  chk("grant", {30'd0, ls_req_ready, if_req_ready}, {30'd0, exp_ls, !exp_ls});
               end else begin
                  chk("no_req_ready", {30'd0, ls_req_ready, if_req_ready}, 32'd0);
               end
            end
            gnt_last = 0;
            if (ls_req_ready && ls_pend) begin
               exp_mem.push_back(ls_cur);
               ls_exp.push_back('{we: ls_cur.we, data: mem_fn(ls_cur.addr)});
               gnt_log.push_back(1'b1);
               ls_pend = 0; busy = 1; gnt_last = 1; ptr_ls = 0;
            end else if (if_req_ready && if_pend) begin
               exp_mem.push_back('{addr: if_cur, we: 1'b0, wdata: 32'd0, wmask: 8'd0});
               if_exp.push_back(mem_fn(if_cur));
               gnt_log.push_back(1'b0);
               if_pend = 0; busy = 1; gnt_last = 1; ptr_ls = 1;
            end
            if (mem_req_valid && mem_req_ready) begin
               mem_inflight = 1;
               mem_cnt = (rsp_lat != 0) ? rsp_lat : int'($urandom_range(1, 4));
               mem_data = mem_fn(mem_addr);
            end
            if (ls_rsp_valid || if_rsp_valid) busy = 0;
         end
         @(posedge clk);
         #1;
         mem_rsp_valid = 0;
         mem_rdata = $urandom;
         if (mem_inflight) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
               mem_rsp_valid = 1; mem_rdata = mem_data; mem_inflight = 0;
            end
         end else if (spur_en && ($urandom % 6 == 0)) begin
            mem_rsp_valid = 1;
         end
         case (rdy_mode)
            0: mem_req_ready = $urandom_range(0, 1) == 1;
            1: mem_req_ready = 0;
            default: mem_req_ready = 1;
         endcase
         if (!rst) begin
            if (!ls_pend) begin
               if (ls_inj.size() > 0) begin
                  ls_cur = ls_inj.pop_front(); ls_pend = 1;
               end else if (rand_en && ($urandom % 3 == 0)) begin
                  ls_cur = '{addr: $urandom, we: $urandom_range(0, 1) == 1,
                             wdata: $urandom, wmask: 8'($urandom)};
                  ls_pend = 1;
               end
            end
            if (!if_pend) begin
               if (if_inj.size() > 0) begin
                  if_cur = if_inj.pop_front(); if_pend = 1;
               end else if (rand_en && ($urandom % 3 == 0)) begin
                  if_cur = $urandom; if_pend = 1;
               end
            end
         end
         // idle requesters drive junk fields to show they are ignored
         ls_req_valid = ls_pend;
         ls_addr  = ls_pend ? ls_cur.addr  : $urandom;
         ls_we    = ls_pend ? ls_cur.we    : $urandom_range(0, 1) == 1;
         ls_wdata = ls_pend ? ls_cur.wdata : $urandom;
         ls_wmask = ls_pend ? ls_cur.wmask : 8'($urandom);
         if_req_valid = if_pend;
         if_addr  = if_pend ? if_cur : $urandom;
      end
   end

   // monitor: pops expectations whenever the DUT presents a transfer
   initial begin
      mreq_t m, e;
      rsp_t r;
      logic [31:0] d;
      hold_v = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_v = 0;
         end else begin
            m = '{addr: mem_addr, we: mem_we, wdata: mem_wdata, wmask: mem_wmask};
            if (hold_v) begin
               chk("req_held_valid", {31'd0, mem_req_valid}, 32'd1);
               chk("req_held_addr", m.addr, held.addr);
               chk("req_held_data", m.wdata, held.wdata);
               chk("req_held_ctl", {23'd0, m.we, m.wmask}, {23'd0, held.we, held.wmask});
            end
            hold_v = mem_req_valid && !mem_req_ready;
            held = m;
            if (mem_req_valid && mem_req_ready) begin
               hs_log.push_back(mem_addr);
               if (exp_mem.size() == 0) begin
                  chk("unexpected_mem_req", 32'd1, 32'd0);
               end else begin
                  e = exp_mem.pop_front();
                  chk("mem_addr", m.addr, e.addr);
                  chk("mem_ctl", {23'd0, m.we, m.wmask}, {23'd0, e.we, e.wmask});
                  if (e.we) chk("mem_wdata", m.wdata, e.wdata);
               end
            end
            if (ls_rsp_valid) begin
               chk("ls_rsp_nonowner", {if_rdata[30:0], if_rsp_valid}, 32'd0);
               ls_rsp_cnt++;
               last_ls_rdata = ls_rdata;
               if (ls_exp.size() == 0) begin
                  chk("unexpected_ls_rsp", 32'd1, 32'd0);
               end else begin
                  r = ls_exp.pop_front();
                  if (!r.we) chk("ls_rdata", ls_rdata, r.data);
               end
            end
            if (if_rsp_valid) begin
               chk("if_rsp_nonowner", {ls_rdata[30:0], ls_rsp_valid}, 32'd0);
               if_rsp_cnt++;
               last_if_rdata = if_rdata;
               if (if_exp.size() == 0) begin
                  chk("unexpected_if_rsp", 32'd1, 32'd0);
               end else begin
                  d = if_exp.pop_front();
                  chk("if_rdata", if_rdata, d);
               end
            end
         end
      end
   end

   task automatic wait_idle(input int budget);
      int n = 0;
      do begin
         @(posedge clk); #5; n++;
      end while (!tb_idle() && n < budget);
      chk("idle_timeout", {31'd0, tb_idle()}, 32'd1);
   endtask

   task automatic wait_until_gnt(input int want, input int budget);
      int n = 0;
      while (gnt_log.size() < want && n < budget) begin
         @(posedge clk); #5; n++;
      end
      chk("grant_timeout", {31'd0, gnt_log.size() >= want}, 32'd1);
   endtask

   task automatic do_reset();
      @(posedge clk); #3; rst = 1;
      @(negedge clk);
      chk("rst_readies", {28'd0, if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}, 32'd0);
      chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
      chk("rst_mem_req", {22'd0, mem_req_valid, mem_we, mem_wmask}, 32'd0);
      chk("rst_mem_addr_data", mem_addr | mem_wdata, 32'd0);
      @(posedge clk); #3; rst = 0;
      gnt_log.delete(); hs_log.delete();
   endtask

   initial begin
      int c0, i0;
      repeat (3) @(posedge clk);
      do_reset();

      // single load
      rdy_mode = 2; rsp_lat = 2; c0 = ls_rsp_cnt; i0 = if_rsp_cnt;
      ls_inj.push_back('{addr: 32'h8000_0010, we: 1'b0, wdata: 32'd0, wmask: 8'd0});
      wait_idle(50);
      chk("single_load_count", ls_rsp_cnt, c0 + 1);
      chk("single_load_data", last_ls_rdata, 32'hDEAD_BEEF);
      chk("single_load_no_if", if_rsp_cnt, i0);

      // simultaneous LS and IF
      do_reset();
      i0 = if_rsp_cnt;
      ls_inj.push_back('{addr: 32'h8000_0020, we: 1'b0, wdata: 32'd0, wmask: 8'd0});
      if_inj.push_back(32'h8000_0000);
      wait_idle(50);
      chk("simul_req_count", hs_log.size(), 2);
      if (hs_log.size() == 2) begin
         chk("simul_first_ls", hs_log[0], 32'h8000_0020);
         chk("simul_second_if", hs_log[1], 32'h8000_0000);
      end
      chk("simul_if_rsp", if_rsp_cnt, i0 + 1);
      chk("simul_if_data", last_if_rdata, mem_fn(32'h8000_0000));

      // both held valid for four grants
      do_reset();
      for (int k = 0; k < 2; k++) begin
         ls_inj.push_back('{addr: 32'h8000_1000 + 32'(k * 4), we: 1'b0, wdata: 32'd0, wmask: 8'd0});
         if_inj.push_back(32'h8000_2000 + 32'(k * 4));
      end
      wait_idle(80);
      chk("four_grants", gnt_log.size(), 4);
      if (gnt_log.size() == 4) begin
`ifdef YSYX22041405_ARB_RR_EN
         chk("grant_order", {28'd0, gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 32'b1010);
`else
         chk("grant_order", {28'd0, gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]}, 32'b1100);
`endif
      end

      // store under 5 cycles of backpressure
      do_reset();
      c0 = ls_rsp_cnt; rdy_mode = 1;
      ls_inj.push_back('{addr: 32'h8000_0100, we: 1'b1, wdata: 32'h1234_5678, wmask: 8'h0F});
      wait_until_gnt(1, 20);
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, mem_req_valid}, 32'd1);
         chk("bp_wdata", mem_wdata, 32'h1234_5678);
         chk("bp_ctl", {23'd0, mem_we, mem_wmask}, {23'd0, 1'b1, 8'h0F});
      end
      rdy_mode = 2;
      wait_idle(50);
      chk("bp_store_ack", ls_rsp_cnt, c0 + 1);

      // reset in WAIT, late response dropped
      do_reset();
      rsp_lat = 5; c0 = ls_rsp_cnt;
      ls_inj.push_back('{addr: 32'h8000_0200, we: 1'b0, wdata: 32'd0, wmask: 8'd0});
      begin
         int n = 0;
         while (hs_log.size() == 0 && n < 20) begin @(posedge clk); #5; n++; end
         chk("wait_hs_timeout", {31'd0, hs_log.size() > 0}, 32'd1);
      end
      @(posedge clk);
      do_reset();
      repeat (8) @(negedge clk);
      chk("late_rsp_dropped", ls_rsp_cnt, c0);
      chk("late_rsp_idle", {30'd0, mem_req_valid, mem_inflight}, 32'd0);
      rsp_lat = 2;
      ls_inj.push_back('{addr: 32'h8000_0010, we: 1'b0, wdata: 32'd0, wmask: 8'd0});
      wait_idle(50);
      chk("post_reset_count", ls_rsp_cnt, c0 + 1);
      chk("post_reset_data", last_ls_rdata, 32'hDEAD_BEEF);

      // random traffic
      do_reset();
      rand_en = 1; spur_en = 1; rdy_mode = 0; rsp_lat = 0;
      repeat (3000) @(posedge clk);
      #5; rand_en = 0;
      wait_idle(300);
      spur_en = 0;
      repeat (3) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
